// File: rtl/race_state_ctrl.sv
// Game sequencer for the racer display: INIT -> IDLE -> COUNTDOWN -> GAME -> FINISHED.
// Owns the lap count and countdown digit, and decodes the layer/enable strobes from the state.
module race_state_ctrl #(
   parameter int INIT_CYCLES     = 16,
   parameter int TICK_DIV        = 65_000_000,
   parameter int COUNTDOWN_STEPS = 3,
   parameter int LAPS            = 3,
   parameter int FINISH_TICKS    = 5,
   localparam int CW             = $clog2(COUNTDOWN_STEPS + 1),
   localparam int LW             = $clog2(LAPS + 1)
) (
   input  logic          pclk,
   input  logic          rst,
   input  logic          btn_start,
   input  logic          abort,
   input  logic          finish_cross,
   output logic          bg_visible,
   output logic          track_visible,
   output logic          player_visible,
   output logic          countdown_visible,
   output logic          player_enable,
   output logic [CW-1:0] countdown_val,
   output logic [LW-1:0] lap,
   output logic          game_over,
   output logic [2:0]    state_out
);

   localparam int TW  = $clog2(TICK_DIV);
   localparam int ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam int FW  = (FINISH_TICKS > 1) ? $clog2(FINISH_TICKS) : 1;

   typedef enum logic [2:0] {
      S_INIT = 3'b000,
      S_IDLE = 3'b001,
      S_GAME = 3'b011,
      S_FIN  = 3'b010,
      S_CD   = 3'b100
   } state_e;

   state_e          state_q;
   logic [TW-1:0]   tick_q;
   logic [ICW-1:0]  init_q;
   logic [FW-1:0]   fin_q;
   logic [CW-1:0]   cd_q;
   logic [LW-1:0]   lap_q;
   logic            btn_prev_q;

   logic            start_edge;
   logic            tick;
   logic [LW-1:0]   lap_d;

   assign start_edge = btn_start & ~btn_prev_q;
   assign tick       = (tick_q == TW'(TICK_DIV - 1));
   assign lap_d      = lap_q + 1'b1;

   // Every transition branch clears tick_q so each state starts its timing from zero.
   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q    <= S_INIT;
         tick_q     <= '0;
         init_q     <= '0;
         fin_q      <= '0;
         cd_q       <= '0;
         lap_q      <= '0;
         btn_prev_q <= 1'b1;
      end else begin
         btn_prev_q <= btn_start;
         tick_q     <= tick ? '0 : tick_q + 1'b1;
         init_q     <= '0;
         case (state_q)
            S_INIT: begin
               tick_q <= '0;
               cd_q   <= '0;
               lap_q  <= '0;
               if (init_q == ICW'(INIT_CYCLES - 1)) begin
                  state_q <= S_IDLE;
               end else begin
                  init_q <= init_q + 1'b1;
               end
            end
            S_IDLE: begin
               if (start_edge) begin
                  state_q <= S_CD;
                  tick_q  <= '0;
                  cd_q    <= CW'(COUNTDOWN_STEPS);
                  lap_q   <= '0;
               end
            end
            S_CD: begin
               if (abort) begin
                  state_q <= S_IDLE;
                  tick_q  <= '0;
                  cd_q    <= '0;
               end else if (tick) begin
                  if (cd_q == CW'(1)) begin
                     state_q <= S_GAME;
                     tick_q  <= '0;
                     cd_q    <= '0;
                  end else begin
                     cd_q <= cd_q - 1'b1;
                  end
               end
            end
            S_GAME: begin
               if (abort) begin
                  state_q <= S_IDLE;
                  tick_q  <= '0;
               end else if (finish_cross) begin
                  lap_q <= lap_d;
                  if (lap_d == LW'(LAPS)) begin
                     state_q <= S_FIN;
                     tick_q  <= '0;
                     fin_q   <= '0;
                  end
               end
            end
            S_FIN: begin
               if (start_edge || (tick && fin_q == FW'(FINISH_TICKS - 1))) begin
                  state_q <= S_IDLE;
                  tick_q  <= '0;
                  fin_q   <= '0;
               end else if (tick) begin
                  fin_q <= fin_q + 1'b1;
               end
            end
            default: begin
               state_q <= S_INIT;
               tick_q  <= '0;
               cd_q    <= '0;
               lap_q   <= '0;
            end
         endcase
      end
   end

   // Both counters are zero only in the first FINISHED cycle, which gives the entry pulse.
   assign game_over         = (state_q == S_FIN) && (tick_q == '0) && (fin_q == '0);
   assign bg_visible        = (state_q == S_IDLE);
   assign track_visible     = (state_q == S_CD) || (state_q == S_GAME) || (state_q == S_FIN);
   assign player_visible    = track_visible;
   assign countdown_visible = (state_q == S_CD);
   assign player_enable     = (state_q == S_GAME);
   assign countdown_val     = cd_q;
   assign lap               = lap_q;
   assign state_out         = state_q;

endmodule

// File: tb/tb_race_state_ctrl.sv
// Directed bench for race_state_ctrl: a cycle table for a full race plus short corner-case sequences.
module tb_race_state_ctrl;

   localparam logic [2:0] ST_INIT = 3'b000;
   localparam logic [2:0] ST_IDLE = 3'b001;
   localparam logic [2:0] ST_GAME = 3'b011;
   localparam logic [2:0] ST_FIN  = 3'b010;
   localparam logic [2:0] ST_CD   = 3'b100;

   // {bg, track, player, countdown, player_enable}
   localparam logic [4:0] V_OFF  = 5'b00000;
   localparam logic [4:0] V_IDLE = 5'b10000;
   localparam logic [4:0] V_CD   = 5'b01110;
   localparam logic [4:0] V_GAME = 5'b01101;
   localparam logic [4:0] V_FIN  = 5'b01100;

   typedef struct packed {
      logic [2:0] st;
      logic [4:0] vis;
      logic [1:0] cv;
      logic [1:0] lap;
      logic       go;
   } obs_t;

   typedef struct {
      logic  rst;
      logic  btn;
      logic  ab;
      logic  fc;
      obs_t  exp;
      string nm;
   } vec_t;

   logic       pclk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_start = 1'b1;
   logic       abort = 1'b0;
   logic       finish_cross = 1'b0;
   logic       bg_visible, track_visible, player_visible, countdown_visible, player_enable;
   logic [1:0] countdown_val;
   logic [1:0] lap;
   logic       game_over;
   logic [2:0] state_out;

   int n_chk = 0;
   int n_fail = 0;
   vec_t tbl[$];

   race_state_ctrl #(
      .INIT_CYCLES(2), .TICK_DIV(4), .COUNTDOWN_STEPS(3), .LAPS(2), .FINISH_TICKS(2)
   ) dut (
      .pclk(pclk), .rst(rst), .btn_start(btn_start), .abort(abort), .finish_cross(finish_cross),
      .bg_visible(bg_visible), .track_visible(track_visible), .player_visible(player_visible),
      .countdown_visible(countdown_visible), .player_enable(player_enable),
      .countdown_val(countdown_val), .lap(lap), .game_over(game_over), .state_out(state_out)
   );

   always #5 pclk = ~pclk;

   function automatic obs_t mk(input logic [2:0] st, input logic [4:0] vis, input int cv,
                               input int lp, input logic go);
      obs_t o;
      o.st = st; o.vis = vis; o.cv = 2'(cv); o.lap = 2'(lp); o.go = go;
      return o;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.st  = state_out;
      o.vis = {bg_visible, track_visible, player_visible, countdown_visible, player_enable};
      o.cv  = countdown_val;
      o.lap = lap;
      o.go  = game_over;
      return o;
   endfunction

   task automatic add(input logic r, input logic b, input logic a, input logic f, input obs_t e,
                      input string nm);
      vec_t v;
      v.rst = r; v.btn = b; v.ab = a; v.fc = f; v.exp = e; v.nm = nm;
      tbl.push_back(v);
   endtask

   task automatic cyc(input logic r, input logic b, input logic a, input logic f);
      rst = r; btn_start = b; abort = a; finish_cross = f;
      @(posedge pclk);
      #1;
   endtask

   task automatic check(input string nm, input obs_t e, input obs_t m);
      obs_t g;
      g = sample();
      n_chk++;
      if (((g ^ e) & m) != '0) begin
         n_fail++;
         $display("FAIL %s: got st=%b vis=%b cv=%0d lap=%0d go=%b, expected st=%b vis=%b cv=%0d lap=%0d go=%b",
                  nm, g.st, g.vis, g.cv, g.lap, g.go, e.st, e.vis, e.cv, e.lap, e.go);
      end
   endtask

   task automatic enter_game(input string nm);
      cyc(0, 1, 0, 0);
      for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0);
      check(nm, mk(ST_GAME, V_GAME, 0, 0, 0), '1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      obs_t no_cv;
      no_cv = '1;
      no_cv.cv = '0;

      // Reset with the button held, INIT, IDLE, and ignored inputs in IDLE
      add(1, 1, 0, 0, mk(ST_INIT, V_OFF, 0, 0, 0), "reset_a");
      add(1, 1, 0, 0, mk(ST_INIT, V_OFF, 0, 0, 0), "reset_b");
      add(0, 1, 0, 0, mk(ST_INIT, V_OFF, 0, 0, 0), "init_2nd_cycle");
      add(0, 1, 0, 0, mk(ST_IDLE, V_IDLE, 0, 0, 0), "idle_entry");
      add(0, 1, 0, 0, mk(ST_IDLE, V_IDLE, 0, 0, 0), "held_btn_no_start");
      add(0, 0, 1, 1, mk(ST_IDLE, V_IDLE, 0, 0, 0), "idle_abort_fc_ignored");
      add(0, 1, 0, 0, mk(ST_CD, V_CD, 3, 0, 0), "cd_cycle1");
      for (int i = 2; i <= 12; i++)
         add(0, 1, 0, (i == 6), mk(ST_CD, V_CD, 3 - (i - 1) / 4, 0, 0), $sformatf("cd_cycle%0d", i));
      add(0, 0, 0, 0, mk(ST_GAME, V_GAME, 0, 0, 0), "game_cycle13");
      add(0, 0, 0, 1, mk(ST_GAME, V_GAME, 0, 1, 0), "lap1");
      for (int i = 0; i < 4; i++)
         add(0, 0, 0, 0, mk(ST_GAME, V_GAME, 0, 1, 0), "game_lap1_hold");
      add(0, 0, 0, 1, mk(ST_FIN, V_FIN, 0, 2, 1), "fin_entry_go");
      for (int i = 2; i <= 8; i++)
         add(0, 0, (i == 3), (i == 4), mk(ST_FIN, V_FIN, 0, 2, 0), $sformatf("fin_cycle%0d", i));
      add(0, 0, 0, 0, mk(ST_IDLE, V_IDLE, 0, 2, 0), "idle_after_fin");
      add(0, 0, 0, 0, mk(ST_IDLE, V_IDLE, 0, 2, 0), "idle_lap_kept");

      foreach (tbl[i]) begin
         cyc(tbl[i].rst, tbl[i].btn, tbl[i].ab, tbl[i].fc);
         check(tbl[i].nm, tbl[i].exp, '1);
      end

      // Start edge mid-countdown must not restart it; abort then returns to IDLE
      cyc(0, 1, 0, 0);
      check("cd_entry_clears_lap", mk(ST_CD, V_CD, 3, 0, 0), '1);
      cyc(0, 0, 0, 0);
      cyc(0, 1, 0, 0);
      check("cd_edge_cycle3", mk(ST_CD, V_CD, 3, 0, 0), '1);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      check("cd_no_restart", mk(ST_CD, V_CD, 2, 0, 0), '1);
      cyc(0, 0, 1, 0);
      check("cd_abort", mk(ST_IDLE, V_IDLE, 0, 0, 0), no_cv);

      // Abort beats a simultaneous finish_cross
      enter_game("game_for_abort");
      cyc(0, 0, 0, 1);
      check("abort_seq_lap1", mk(ST_GAME, V_GAME, 0, 1, 0), '1);
      cyc(0, 0, 1, 1);
      check("abort_priority", mk(ST_IDLE, V_IDLE, 0, 1, 0), '1);
      cyc(0, 0, 0, 0);
      check("abort_no_game_over", mk(ST_IDLE, V_IDLE, 0, 1, 0), '1);

      // Reset in the middle of a race
      enter_game("game_for_reset");
      cyc(0, 0, 0, 1);
      check("reset_seq_lap1", mk(ST_GAME, V_GAME, 0, 1, 0), '1);
      cyc(1, 0, 0, 0);
      check("midrace_reset", mk(ST_INIT, V_OFF, 0, 0, 0), '1);
      cyc(0, 0, 0, 0);
      check("midrace_reset_init", mk(ST_INIT, V_OFF, 0, 0, 0), '1);
      cyc(0, 0, 0, 0);
      check("midrace_reset_idle", mk(ST_IDLE, V_IDLE, 0, 0, 0), '1);

      // Start edge on the third FINISHED cycle leaves early
      enter_game("game_for_early_exit");
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      check("early_fin_entry", mk(ST_FIN, V_FIN, 0, 2, 1), '1);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      check("early_fin_cycle3", mk(ST_FIN, V_FIN, 0, 2, 0), '1);
      cyc(0, 1, 0, 0);
      check("early_exit_idle", mk(ST_IDLE, V_IDLE, 0, 2, 0), '1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
